lsu_mem_port: RTL and testbench

- Data-memory side of the core's load/store path; produces the word the write-back mux selects on reg_src_sel = 3'b001 (mem data).
- Accepts one load/store from EX and drives a single-outstanding req/ack data-memory bus.
- Formats load data (byte/half extract, sign/zero extend) and generates byte strobes for stores.
- Stalls the pipeline while busy; flags misaligned, illegal-size and timed-out accesses.

---
 rtl/lsu_mem_port_pkg.sv | 56 +++++
 rtl/lsu_mem_port_if.sv | 22 ++
 rtl/lsu_load_align.sv | 24 ++
 rtl/lsu_mem_port.sv | 147 ++++++++++++++
 tb/tb_lsu_mem_port.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_port_pkg.sv
// rtl/lsu_mem_port_pkg.sv - shared load/store size codes, error codes, state encoding and store helpers
package lsu_mem_port_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } lsu_state_e;

    function automatic logic funct3_legal(input logic [2:0] f3);
        logic ok;
        ok = (f3 == LS_B) || (f3 == LS_H) || (f3 == LS_W) || (f3 == LS_BU) || (f3 == LS_HU);
        return ok;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3)
            LS_H, LS_HU: mis = lo[0];
            LS_W:        mis = (lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Only B/H/W reach these helpers for stores, so funct3[1:0] alone selects the size.
    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] strb;
        case (f3[1:0])
            2'b00:   strb = 4'b0001 << lo;
            2'b01:   strb = 4'b0011 << lo;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// rtl/lsu_mem_port_if.sv - single-outstanding req/ack data-memory bus
interface lsu_mem_port_if #(
    parameter int ADDR_W = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - extracts and extends a byte/half/word from a 32-bit read word
module lsu_load_align
    import lsu_mem_port_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(rdata >> {addr_lo, 3'b000});
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LS_B:    data = {{24{byte_sel[7]}}, byte_sel};
            LS_BU:   data = {24'h0, byte_sel};
            LS_H:    data = {{16{half_sel[15]}}, half_sel};
            LS_HU:   data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store unit memory port: op validation, req/ack bus, timeout, load formatting
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [2:0]        ex_funct3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    output logic              ex_accept,
    output logic              lsu_busy,
    lsu_mem_port_if.master    mem,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              lsu_err,
    output logic [1:0]        lsu_err_code
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lo_q, lo_d;
    logic [2:0]        f3_q, f3_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [31:0]       align_data;
    logic              illegal;

    lsu_load_align u_align (
        .rdata   (mem.mem_rdata),
        .addr_lo (lo_q),
        .funct3  (f3_q),
        .data    (align_data)
    );

    assign ex_accept = ~rst & (state_q == ST_IDLE) & ex_valid & (ex_is_load | ex_is_store);
    assign illegal   = (ex_is_load & ex_is_store) | ~funct3_legal(ex_funct3)
                     | (ex_is_store & ex_funct3[2]);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lo_d         = lo_q;
        f3_d         = f3_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        case (state_q)
            ST_IDLE: begin
                if (ex_accept) begin
                    if (illegal) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ILLEGAL;
                    end else if (is_misaligned(ex_funct3, ex_addr[1:0])) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_MISALIGN;
                    end else begin
                        state_d = ST_REQ;
                        addr_d  = {ex_addr[ADDR_W-1:2], 2'b00};
                        lo_d    = ex_addr[1:0];
                        f3_d    = ex_funct3;
                        we_d    = ex_is_store;
                        wdata_d = store_data(ex_funct3, ex_wdata);
                        wstrb_d = ex_is_store ? store_strb(ex_funct3, ex_addr[1:0]) : 4'b0000;
                        cnt_d   = '0;
                    end
                end
            end
            ST_REQ: begin
                // An ack in the final timeout cycle still completes normally.
                if (mem.mem_ack) begin
                    state_d = ST_IDLE;
                    if (!we_q) begin
                        load_data_d  = align_data;
                        load_valid_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            lo_q         <= '0;
            f3_q         <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            cnt_q        <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            lo_q         <= lo_d;
            f3_q         <= f3_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign lsu_busy      = (state_q == ST_REQ);
    assign mem.mem_req   = (state_q == ST_REQ);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wstrb = wstrb_q;
    assign load_data     = load_data_q;
    assign load_valid    = load_valid_q;
    assign lsu_err       = err_q;
    assign lsu_err_code  = err_code_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - directed self-checking bench for lsu_mem_port
module tb_lsu_mem_port;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_store = 1'b0;
    logic [2:0]  ex_funct3 = 3'b000;
    logic [31:0] ex_addr = 32'h0, ex_wdata = 32'h0;
    logic        ex_accept, lsu_busy, load_valid, lsu_err;
    logic [31:0] load_data;
    logic [1:0]  lsu_err_code;
    int          n_cmp = 0;
    int          n_bad = 0;

    lsu_mem_port_if #(.ADDR_W(32)) mif ();

    lsu_mem_port #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_is_load   (ex_is_load),
        .ex_is_store  (ex_is_store),
        .ex_funct3    (ex_funct3),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_accept    (ex_accept),
        .lsu_busy     (lsu_busy),
        .mem          (mif),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .lsu_err      (lsu_err),
        .lsu_err_code (lsu_err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
        ex_funct3 = f3; ex_addr = a; ex_wdata = wd;
        #1;
    endtask

    task automatic idle_op();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        n_cmp++; if (mif.mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got=%h exp=0", mif.mem_req); end
        n_cmp++; if (lsu_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%h exp=0", lsu_busy); end
        n_cmp++; if (load_valid !== 1'b0) begin n_bad++; $display("FAIL rst_lvalid got=%h exp=0", load_valid); end
        n_cmp++; if (lsu_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%h exp=0", lsu_err); end
        n_cmp++; if (lsu_err_code !== 2'b00) begin n_bad++; $display("FAIL rst_code got=%h exp=0", lsu_err_code); end
        n_cmp++; if (load_data !== 32'h0) begin n_bad++; $display("FAIL rst_ldata got=%h exp=0", load_data); end
        n_cmp++; if (mif.mem_wstrb !== 4'h0) begin n_bad++; $display("FAIL rst_wstrb got=%h exp=0", mif.mem_wstrb); end
        n_cmp++; if (ex_accept !== 1'b0) begin n_bad++; $display("FAIL rst_accept got=%h exp=0", ex_accept); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lb_sign();
        drive_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
        n_cmp++; if (ex_accept !== 1'b1) begin n_bad++; $display("FAIL lb_accept got=%h exp=1", ex_accept); end
        @(negedge clk); idle_op();
        n_cmp++; if (mif.mem_req !== 1'b1) begin n_bad++; $display("FAIL lb_req got=%h exp=1", mif.mem_req); end
        n_cmp++; if (lsu_busy !== 1'b1) begin n_bad++; $display("FAIL lb_busy got=%h exp=1", lsu_busy); end
        @(negedge clk);
        n_cmp++; if (load_valid !== 1'b0) begin n_bad++; $display("FAIL lb_early_valid got=%h exp=0", load_valid); end
        @(negedge clk); mif.mem_ack = 1'b1; mif.mem_rdata = 32'h8000_0000;
        @(negedge clk); mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
        n_cmp++; if (load_valid !== 1'b1) begin n_bad++; $display("FAIL lb_valid got=%h exp=1", load_valid); end
        n_cmp++; if (load_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_data got=%h exp=ffffff80", load_data); end
        @(negedge clk);
        n_cmp++; if (load_valid !== 1'b0) begin n_bad++; $display("FAIL lb_pulse_width got=%h exp=0", load_valid); end
        n_cmp++; if (load_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_hold got=%h exp=ffffff80", load_data); end
    endtask

    task automatic test_lhu_zero_wait();
        drive_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0);
        n_cmp++; if (ex_accept !== 1'b1) begin n_bad++; $display("FAIL lhu_accept got=%h exp=1", ex_accept); end
        @(negedge clk); idle_op();
        n_cmp++; if (mif.mem_addr !== 32'h100) begin n_bad++; $display("FAIL lhu_addr got=%h exp=100", mif.mem_addr); end
        n_cmp++; if (mif.mem_wstrb !== 4'b0000) begin n_bad++; $display("FAIL lhu_wstrb got=%h exp=0", mif.mem_wstrb); end
        n_cmp++; if (mif.mem_we !== 1'b0) begin n_bad++; $display("FAIL lhu_we got=%h exp=0", mif.mem_we); end
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hBEEF_1234;
        @(negedge clk); mif.mem_ack = 1'b0;
        n_cmp++; if (load_valid !== 1'b1) begin n_bad++; $display("FAIL lhu_valid got=%h exp=1", load_valid); end
        n_cmp++; if (load_data !== 32'h0000_BEEF) begin n_bad++; $display("FAIL lhu_data got=%h exp=0000beef", load_data); end
        n_cmp++; if (lsu_busy !== 1'b0) begin n_bad++; $display("FAIL lhu_busy got=%h exp=0", lsu_busy); end
    endtask

    task automatic test_sb();
        drive_op(1'b0, 1'b1, 3'b000, 32'h201, 32'h0000_00A5);
        n_cmp++; if (ex_accept !== 1'b1) begin n_bad++; $display("FAIL sb_accept got=%h exp=1", ex_accept); end
        @(negedge clk); idle_op();
        n_cmp++; if (mif.mem_we !== 1'b1) begin n_bad++; $display("FAIL sb_we got=%h exp=1", mif.mem_we); end
        n_cmp++; if (mif.mem_wstrb !== 4'b0010) begin n_bad++; $display("FAIL sb_wstrb got=%h exp=2", mif.mem_wstrb); end
        n_cmp++; if (mif.mem_wdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", mif.mem_wdata); end
        n_cmp++; if (mif.mem_addr !== 32'h200) begin n_bad++; $display("FAIL sb_addr got=%h exp=200", mif.mem_addr); end
        mif.mem_ack = 1'b1;
        @(negedge clk); mif.mem_ack = 1'b0;
        n_cmp++; if (load_valid !== 1'b0) begin n_bad++; $display("FAIL sb_no_valid got=%h exp=0", load_valid); end
        n_cmp++; if (load_data !== 32'h0000_BEEF) begin n_bad++; $display("FAIL sb_ldata_hold got=%h exp=0000beef", load_data); end
        n_cmp++; if (lsu_busy !== 1'b0) begin n_bad++; $display("FAIL sb_busy got=%h exp=0", lsu_busy); end
    endtask

    task automatic test_errors();
        logic        ld_t [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        st_t [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3_t [6] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b011, 3'b101};
        logic [31:0] a_t  [6] = '{32'h102, 32'h200, 32'h201, 32'h200, 32'h200, 32'h103};
        logic [1:0]  c_t  [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 6; i++) begin
            drive_op(ld_t[i], st_t[i], f3_t[i], a_t[i], 32'h1234_5678);
            n_cmp++; if (ex_accept !== 1'b1) begin n_bad++; $display("FAIL err%0d_accept got=%h exp=1", i, ex_accept); end
            @(negedge clk); idle_op();
            n_cmp++; if (lsu_err !== 1'b1) begin n_bad++; $display("FAIL err%0d_pulse got=%h exp=1", i, lsu_err); end
            n_cmp++; if (lsu_err_code !== c_t[i]) begin n_bad++; $display("FAIL err%0d_code got=%h exp=%h", i, lsu_err_code, c_t[i]); end
            n_cmp++; if (mif.mem_req !== 1'b0) begin n_bad++; $display("FAIL err%0d_req got=%h exp=0", i, mif.mem_req); end
            @(negedge clk);
            n_cmp++; if (lsu_err !== 1'b0) begin n_bad++; $display("FAIL err%0d_width got=%h exp=0", i, lsu_err); end
            n_cmp++; if (lsu_err_code !== c_t[i]) begin n_bad++; $display("FAIL err%0d_hold got=%h exp=%h", i, lsu_err_code, c_t[i]); end
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        drive_op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) idle_op();
            if (mif.mem_req === 1'b1) req_cycles++;
            else break;
        end
        n_cmp++; if (req_cycles !== 16) begin n_bad++; $display("FAIL to_req_cycles got=%0d exp=16", req_cycles); end
        n_cmp++; if (lsu_err !== 1'b1) begin n_bad++; $display("FAIL to_err got=%h exp=1", lsu_err); end
        n_cmp++; if (lsu_err_code !== 2'b11) begin n_bad++; $display("FAIL to_code got=%h exp=3", lsu_err_code); end
        n_cmp++; if (lsu_busy !== 1'b0) begin n_bad++; $display("FAIL to_busy got=%h exp=0", lsu_busy); end
        drive_op(1'b1, 1'b0, 3'b010, 32'h108, 32'h0);
        n_cmp++; if (ex_accept !== 1'b1) begin n_bad++; $display("FAIL to_next_accept got=%h exp=1", ex_accept); end
        @(negedge clk); idle_op();
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1234_5678;
        @(negedge clk); mif.mem_ack = 1'b0;
        n_cmp++; if (load_data !== 32'h1234_5678) begin n_bad++; $display("FAIL to_next_data got=%h exp=12345678", load_data); end
    endtask

    task automatic test_timeout_race();
        drive_op(1'b1, 1'b0, 3'b010, 32'h10C, 32'h0);
        @(negedge clk); idle_op();
        repeat (15) @(negedge clk);
        n_cmp++; if (mif.mem_req !== 1'b1) begin n_bad++; $display("FAIL race_req got=%h exp=1", mif.mem_req); end
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0BAD_F00D;
        @(negedge clk); mif.mem_ack = 1'b0;
        n_cmp++; if (load_valid !== 1'b1) begin n_bad++; $display("FAIL race_valid got=%h exp=1", load_valid); end
        n_cmp++; if (lsu_err !== 1'b0) begin n_bad++; $display("FAIL race_err got=%h exp=0", lsu_err); end
        n_cmp++; if (load_data !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL race_data got=%h exp=0badf00d", load_data); end
    endtask

    task automatic test_back_to_back();
        drive_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0);
        @(negedge clk); idle_op();
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h8001_0000;
        @(negedge clk); mif.mem_ack = 1'b0;
        n_cmp++; if (load_data !== 32'hFFFF_8001) begin n_bad++; $display("FAIL lh_data got=%h exp=ffff8001", load_data); end
        drive_op(1'b1, 1'b0, 3'b100, 32'h101, 32'h0);
        n_cmp++; if (ex_accept !== 1'b1) begin n_bad++; $display("FAIL b2b_accept got=%h exp=1", ex_accept); end
        @(negedge clk); idle_op();
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0000_F000;
        @(negedge clk); mif.mem_ack = 1'b0;
        n_cmp++; if (load_data !== 32'h0000_00F0) begin n_bad++; $display("FAIL lbu_data got=%h exp=000000f0", load_data); end
        drive_op(1'b0, 1'b1, 3'b001, 32'h302, 32'h1234_BEEF);
        @(negedge clk); idle_op();
        n_cmp++; if (mif.mem_wstrb !== 4'b1100) begin n_bad++; $display("FAIL sh_wstrb got=%h exp=c", mif.mem_wstrb); end
        n_cmp++; if (mif.mem_wdata !== 32'hBEEF_BEEF) begin n_bad++; $display("FAIL sh_wdata got=%h exp=beefbeef", mif.mem_wdata); end
        mif.mem_ack = 1'b1;
        @(negedge clk); mif.mem_ack = 1'b0;
        drive_op(1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFE_F00D);
        @(negedge clk); idle_op();
        n_cmp++; if (mif.mem_wstrb !== 4'b1111) begin n_bad++; $display("FAIL sw_wstrb got=%h exp=f", mif.mem_wstrb); end
        n_cmp++; if (mif.mem_wdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL sw_wdata got=%h exp=cafef00d", mif.mem_wdata); end
        mif.mem_ack = 1'b1;
        @(negedge clk); mif.mem_ack = 1'b0;
    endtask

    task automatic test_ignored();
        drive_op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
        @(negedge clk);
        drive_op(1'b0, 1'b1, 3'b000, 32'h600, 32'hFF);
        n_cmp++; if (ex_accept !== 1'b0) begin n_bad++; $display("FAIL busy_accept got=%h exp=0", ex_accept); end
        @(negedge clk); idle_op();
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1122_3344;
        @(negedge clk);
        n_cmp++; if (load_data !== 32'h1122_3344) begin n_bad++; $display("FAIL busy_ldata got=%h exp=11223344", load_data); end
        mif.mem_rdata = 32'h5555_5555;
        @(negedge clk); mif.mem_ack = 1'b0;
        n_cmp++; if (load_valid !== 1'b0) begin n_bad++; $display("FAIL idle_ack_valid got=%h exp=0", load_valid); end
        n_cmp++; if (mif.mem_req !== 1'b0) begin n_bad++; $display("FAIL idle_ack_req got=%h exp=0", mif.mem_req); end
    endtask

    task automatic test_reset_mid_req();
        drive_op(1'b1, 1'b0, 3'b010, 32'h10C, 32'h0);
        @(negedge clk); idle_op();
        n_cmp++; if (mif.mem_req !== 1'b1) begin n_bad++; $display("FAIL rmid_req_before got=%h exp=1", mif.mem_req); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_cmp++; if (mif.mem_req !== 1'b0) begin n_bad++; $display("FAIL rmid_req got=%h exp=0", mif.mem_req); end
        n_cmp++; if (lsu_busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got=%h exp=0", lsu_busy); end
        n_cmp++; if (load_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got=%h exp=0", load_valid); end
        n_cmp++; if (load_data !== 32'h0) begin n_bad++; $display("FAIL rmid_ldata got=%h exp=0", load_data); end
        n_cmp++; if (lsu_err_code !== 2'b00) begin n_bad++; $display("FAIL rmid_code got=%h exp=0", lsu_err_code); end
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk); mif.mem_ack = 1'b0;
        n_cmp++; if (load_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_late_ack got=%h exp=0", load_valid); end
        n_cmp++; if (load_data !== 32'h0) begin n_bad++; $display("FAIL rmid_late_data got=%h exp=0", load_data); end
    endtask

    initial begin
        mif.mem_ack = 1'b0;
        mif.mem_rdata = 32'h0;
        test_reset();
        test_lb_sign();
        test_lhu_zero_wait();
        test_sb();
        test_errors();
        test_timeout();
        test_timeout_race();
        test_back_to_back();
        test_ignored();
        test_reset_mid_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
